// File: rtl/registered_adder_if.sv
// ----------------------------------------------------------------------------
// registered_adder_if
// Operand/result bundle for the registered_adder leaf cell.
//   in_valid  : operands a/b/cin valid this cycle        (master -> slave)
//   a, b      : unsigned WORD_WIDTH-bit operands          (master -> slave)
//   cin       : carry-in, tie 0 for a plain add           (master -> slave)
//   out_valid : y/cout/ovf hold a valid result            (slave -> master)
//   y         : registered sum, (a+b+cin) mod 2^WORD_WIDTH (slave -> master)
//   cout      : registered carry-out of the MSB           (slave -> master)
//   ovf       : registered two's-complement overflow flag (slave -> master)
// The adder itself connects through the slave modport; the operand source
// (PE accumulator, reduction tree node, bench) uses the master modport.
// ----------------------------------------------------------------------------
interface registered_adder_if #(
  parameter int WORD_WIDTH = 8
) ();

  logic                  in_valid;
  logic [WORD_WIDTH-1:0] a;
  logic [WORD_WIDTH-1:0] b;
  logic                  cin;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] y;
  logic                  cout;
  logic                  ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    input  out_valid,
    input  y,
    input  cout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    output out_valid,
    output y,
    output cout,
    output ovf
  );

endinterface : registered_adder_if

// File: rtl/registered_adder.sv
// ----------------------------------------------------------------------------
// registered_adder
// Unsigned WORD_WIDTH-bit adder with carry-in, carry-out and signed overflow,
// result registered once on clk. Arithmetic leaf for PE accumulators and
// reduction trees in the systolic-array datapath.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset; clears out_valid/y/cout/ovf
//   bus   : registered_adder_if.slave (in_valid, a, b, cin in;
//           out_valid, y, cout, ovf out -- all outputs straight from flops)
//
// Core: carry-lookahead inside 4-bit groups, group carry-out rippling into
// the next group. A partial top group is padded with zero operand bits, so
// the padded positions have g=p=0 and can never inject a carry or an X.
// ----------------------------------------------------------------------------
module registered_adder #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  registered_adder_if.slave     bus
);

  // Number of 4-bit lookahead groups and the padded operand width.
  localparam int NUM_GROUPS = (WORD_WIDTH + 3) / 4;
  localparam int PAD_WIDTH  = NUM_GROUPS * 4;

  // --------------------------------------------------------------------------
  // 4-bit lookahead helper: returns carries into bit positions 1..4 of the
  // group (index 3 is the group carry-out), fully expanded so that every
  // carry is a two-level function of g, p and the group carry-in.
  // --------------------------------------------------------------------------
  function automatic logic [3:0] cla4(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       ci
  );
    logic [3:0] c;
    c[0] = g[0]
         | (p[0] & ci);
    c[1] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[2] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Zero-extended operands and per-bit generate/propagate.
  logic [PAD_WIDTH-1:0]  a_pad_s;
  logic [PAD_WIDTH-1:0]  b_pad_s;
  logic [PAD_WIDTH-1:0]  g_s;
  logic [PAD_WIDTH-1:0]  p_s;

  // carry_s[i] is the carry into bit i; carry_s[WORD_WIDTH] is the carry-out.
  logic [WORD_WIDTH:0]   carry_s;

  // Combinational results of the core.
  logic [WORD_WIDTH-1:0] y_c_s;
  logic                  cout_c_s;
  logic                  ovf_c_s;

  // Output register stage.
  logic                  out_valid_d;
  logic                  out_valid_q;
  logic [WORD_WIDTH-1:0] y_d;
  logic [WORD_WIDTH-1:0] y_q;
  logic                  cout_d;
  logic                  cout_q;
  logic                  ovf_d;
  logic                  ovf_q;

  assign a_pad_s = PAD_WIDTH'(bus.a);
  assign b_pad_s = PAD_WIDTH'(bus.b);
  assign g_s     = a_pad_s & b_pad_s;
  assign p_s     = a_pad_s ^ b_pad_s;

  // Carry chain: lookahead within each group, ripple between groups.
  always_comb begin : carry_chain
    logic [3:0] grp_v;
    logic       ripple_v;
    carry_s    = '0;
    grp_v      = 4'b0000;
    ripple_v   = bus.cin;
    carry_s[0] = bus.cin;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      grp_v = cla4(g_s[4*k +: 4], p_s[4*k +: 4], ripple_v);
      for (int j = 0; j < 4; j++) begin
        // Carries beyond the carry-out position belong to padding only.
        if ((4*k + j + 1) <= WORD_WIDTH) begin
          carry_s[4*k + j + 1] = grp_v[j];
        end else begin
          carry_s = carry_s;
        end
      end
      ripple_v = grp_v[3];
    end
  end

  assign y_c_s    = p_s[WORD_WIDTH-1:0] ^ carry_s[WORD_WIDTH-1:0];
  assign cout_c_s = carry_s[WORD_WIDTH];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_c_s  = carry_s[WORD_WIDTH] ^ carry_s[WORD_WIDTH-1];

  // Next-state: capture on in_valid, otherwise drop valid and hold the data.
  always_comb begin
    out_valid_d = 1'b0;
    y_d         = y_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (bus.in_valid) begin
      out_valid_d = 1'b1;
      y_d         = y_c_s;
      cout_d      = cout_c_s;
      ovf_d       = ovf_c_s;
    end else begin
      out_valid_d = 1'b0;
      y_d         = y_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
    end
  end

  // Output register stage; reset discards any in-flight result immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule : registered_adder

// File: tb/tb_registered_adder.sv
// ----------------------------------------------------------------------------
// tb_registered_adder
// Directed vectors on an 8-bit instance, then a randomised stream compared
// against a+b+cin on 8-, 13- and 32-bit instances running side by side.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_registered_adder;

  logic clk;
  logic reset;

  int checks_cnt;
  int errors_cnt;

  registered_adder_if #(.WORD_WIDTH(8))  if8  ();
  registered_adder_if #(.WORD_WIDTH(13)) if13 ();
  registered_adder_if #(.WORD_WIDTH(32)) if32 ();

  registered_adder #(.WORD_WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  registered_adder #(.WORD_WIDTH(13)) dut13 (.clk(clk), .reset(reset), .bus(if13.slave));
  registered_adder #(.WORD_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison, report it when observed differs from expected.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    if8.in_valid = v;
    if8.a        = a;
    if8.b        = b;
    if8.cin      = c;
  endtask

  task automatic check8(input string tag, input logic v, input logic [7:0] y,
                        input logic co, input logic ov);
    check_val({tag, ".valid"}, 64'(if8.out_valid), 64'(v));
    check_val({tag, ".y"},     64'(if8.y),         64'(y));
    check_val({tag, ".cout"},  64'(if8.cout),      64'(co));
    check_val({tag, ".ovf"},   64'(if8.ovf),       64'(ov));
  endtask

  // Reference: returns {ovf, cout, y} for a width-w add.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
    logic [63:0] sum;
    logic [63:0] mask;
    logic [63:0] y;
    logic        co;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    sum  = a + b + 64'(c);
    y    = sum & mask;
    co   = sum[w];
    ov   = (a[w-1] == b[w-1]) && (y[w-1] != a[w-1]);
    return {ov, co, y};
  endfunction

  // Per-width model state for the random phase: {valid, ovf, cout, y}.
  logic [63:0] exp_y   [3];
  logic        exp_co  [3];
  logic        exp_ov  [3];
  logic        exp_v   [3];

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rv;
    logic [65:0] r;
    int          widths [3];
    widths = '{8, 13, 32};
    checks_cnt = 0;
    errors_cnt = 0;

    // Reset held with a valid operand pair present.
    reset = 1'b1;
    drive8(1'b1, 8'd5, 8'd5, 1'b0);
    if13.in_valid = 1'b0; if13.a = 13'd0; if13.b = 13'd0; if13.cin = 1'b0;
    if32.in_valid = 1'b0; if32.a = 32'd0; if32.b = 32'd0; if32.cin = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check8("reset_hold", 1'b0, 8'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check8("first_after_reset", 1'b1, 8'd10, 1'b0, 1'b0);

    // Back-to-back stream.
    drive8(1'b1, 8'd1, 8'd3, 1'b0);
    @(negedge clk); check8("s_1_3", 1'b1, 8'd4, 1'b0, 1'b0);
    drive8(1'b1, 8'd3, 8'd2, 1'b0);
    @(negedge clk); check8("s_3_2", 1'b1, 8'd5, 1'b0, 1'b0);
    drive8(1'b1, 8'd23, 8'd37, 1'b0);
    @(negedge clk); check8("s_23_37", 1'b1, 8'd60, 1'b0, 1'b0);
    // in_valid drops while operand data keeps changing: outputs must hold.
    drive8(1'b0, 8'd99, 8'd200, 1'b1);
    @(negedge clk); check8("hold", 1'b0, 8'd60, 1'b0, 1'b0);

    // Carry and overflow cases.
    drive8(1'b1, 8'd200, 8'd100, 1'b0);
    @(negedge clk); check8("c_200_100", 1'b1, 8'd44, 1'b1, 1'b0);
    drive8(1'b1, 8'd255, 8'd1, 1'b0);
    @(negedge clk); check8("c_255_1", 1'b1, 8'd0, 1'b1, 1'b0);
    drive8(1'b1, 8'd255, 8'd255, 1'b1);
    @(negedge clk); check8("c_255_255_1", 1'b1, 8'd255, 1'b1, 1'b0);
    drive8(1'b1, 8'd127, 8'd1, 1'b0);
    @(negedge clk); check8("o_127_1", 1'b1, 8'd128, 1'b0, 1'b1);
    drive8(1'b1, 8'd128, 8'd128, 1'b0);
    @(negedge clk); check8("o_128_128", 1'b1, 8'd0, 1'b1, 1'b1);
    drive8(1'b1, 8'd10, 8'd20, 1'b0);
    @(negedge clk); check8("pre_async", 1'b1, 8'd30, 1'b0, 1'b0);

    // Asynchronous reset between edges clears outputs at once.
    #2 reset = 1'b1;
    #1 check8("async_reset", 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b0;

    // Randomised stream on all three widths; model starts from reset state.
    for (int k = 0; k < 3; k++) begin
      exp_y[k] = 64'd0; exp_co[k] = 1'b0; exp_ov[k] = 1'b0; exp_v[k] = 1'b0;
    end
    for (int i = 0; i <= 1000; i++) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin
            check_val("r8.valid", 64'(if8.out_valid), 64'(exp_v[0]));
            check_val("r8.y",     64'(if8.y),         exp_y[0]);
            check_val("r8.cout",  64'(if8.cout),      64'(exp_co[0]));
            check_val("r8.ovf",   64'(if8.ovf),       64'(exp_ov[0]));
          end
          1: begin
            check_val("r13.valid", 64'(if13.out_valid), 64'(exp_v[1]));
            check_val("r13.y",     64'(if13.y),         exp_y[1]);
            check_val("r13.cout",  64'(if13.cout),      64'(exp_co[1]));
            check_val("r13.ovf",   64'(if13.ovf),       64'(exp_ov[1]));
          end
          default: begin
            check_val("r32.valid", 64'(if32.out_valid), 64'(exp_v[2]));
            check_val("r32.y",     64'(if32.y),         exp_y[2]);
            check_val("r32.cout",  64'(if32.cout),      64'(exp_co[2]));
            check_val("r32.ovf",   64'(if32.ovf),       64'(exp_ov[2]));
          end
        endcase
        ra = {32'($urandom), 32'($urandom)} & ((64'd1 << widths[k]) - 64'd1);
        rb = {32'($urandom), 32'($urandom)} & ((64'd1 << widths[k]) - 64'd1);
        // Bias some vectors to all-ones to exercise long carry chains.
        if ($urandom_range(7, 0) == 0) ra = (64'd1 << widths[k]) - 64'd1;
        rc = 1'($urandom_range(1, 0));
        rv = ($urandom_range(7, 0) != 0);
        case (k)
          0: begin if8.in_valid = rv;  if8.a = 8'(ra);   if8.b = 8'(rb);   if8.cin = rc; end
          1: begin if13.in_valid = rv; if13.a = 13'(ra); if13.b = 13'(rb); if13.cin = rc; end
          default: begin if32.in_valid = rv; if32.a = 32'(ra); if32.b = 32'(rb); if32.cin = rc; end
        endcase
        exp_v[k] = rv;
        if (rv) begin
          r = ref_add(widths[k], ra, rb, rc);
          exp_y[k]  = r[63:0];
          exp_co[k] = r[64];
          exp_ov[k] = r[65];
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_registered_adder
